// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

   localparam int NUM_LINES      = 16;
   localparam int WORDS_PER_LINE = 4;
   localparam int WORD_W         = 32;
   localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
   localparam int WSEL_W         = $clog2(WORDS_PER_LINE);
   localparam int INDEX_W        = $clog2(NUM_LINES);
   localparam int TAG_W          = 32 - INDEX_W - WSEL_W - 2;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } state_t;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } line_meta_t;

   // Line-aligned byte address built from a tag and an index.
   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   tag,
                                             input logic [INDEX_W-1:0] idx);
      return {tag, idx, {(WSEL_W + 2){1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache.
interface dcache_if;
   import dcache_pkg::*;

   logic [31:0]       cpu_addr_i;
   logic [31:0]       cpu_data_i;
   logic              cpu_MemRead_i;
   logic              cpu_MemWrite_i;
   logic [31:0]       cpu_data_o;
   logic              cpu_stall_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [31:0]       mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;

   // Cache side.
   modport slave (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      output cpu_data_o, cpu_stall_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   // Pipeline and backing-memory side.
   modport master (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      input  cpu_data_o, cpu_stall_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage: asynchronous read, one synchronous write port.
module dcache_sram
   import dcache_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [INDEX_W-1:0]        idx_i,
   output line_meta_t                meta_o,
   output logic [LINE_W-1:0]         line_o,
   input  logic                      meta_we_i,
   input  line_meta_t                meta_i,
   input  logic                      line_we_i,
   input  logic [LINE_W-1:0]         line_i,
   input  logic [WORDS_PER_LINE-1:0] word_mask_i,
   input  logic [WORD_W-1:0]         word_i
);

   line_meta_t        meta_q [NUM_LINES];
   logic [LINE_W-1:0] data_q [NUM_LINES];

   assign meta_o = meta_q[idx_i];
   assign line_o = data_q[idx_i];

   // Metadata: reset invalidates and cleans every line; tags keep their contents.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            meta_q[i].valid <= 1'b0;
            meta_q[i].dirty <= 1'b0;
         end
      end else if (meta_we_i) begin
         meta_q[idx_i] <= meta_i;
      end
   end

   // Data: full-line refill takes priority over masked word stores.
   always_ff @(posedge clk_i) begin
      if (line_we_i) begin
         data_q[idx_i] <= line_i;
      end else begin
         for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (word_mask_i[w]) data_q[idx_i][w*WORD_W +: WORD_W] <= word_i;
         end
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   dcache_if.slave  bus
);

   state_t                    state_q, state_d;
   line_meta_t                meta, meta_wr;
   logic [LINE_W-1:0]         line;
   logic                      meta_we, line_we;
   logic [WORDS_PER_LINE-1:0] word_mask;
   logic [TAG_W-1:0]          req_tag;
   logic [INDEX_W-1:0]        idx;
   logic [WSEL_W-1:0]         wsel;
   logic                      req, hit;

   assign req_tag = bus.cpu_addr_i[31 -: TAG_W];
   assign idx     = bus.cpu_addr_i[WSEL_W + 2 +: INDEX_W];
   assign wsel    = bus.cpu_addr_i[2 +: WSEL_W];
   assign req     = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   assign hit     = meta.valid && (meta.tag == req_tag);

   dcache_sram u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .idx_i       (idx),
      .meta_o      (meta),
      .line_o      (line),
      .meta_we_i   (meta_we),
      .meta_i      (meta_wr),
      .line_we_i   (line_we),
      .line_i      (bus.mem_data_i),
      .word_mask_i (word_mask),
      .word_i      (bus.cpu_data_i)
   );

   // FSM state register; reset abandons any memory transaction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, memory request and array write controls.
   always_comb begin
      state_d          = state_q;
      bus.mem_enable_o = 1'b0;
      bus.mem_write_o  = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_data_o   = '0;
      meta_we          = 1'b0;
      meta_wr          = '0;
      line_we          = 1'b0;
      word_mask        = '0;
      case (state_q)
         IDLE: begin
            if (req && !hit) begin
               state_d = (meta.valid && meta.dirty) ? WRITEBACK : ALLOCATE;
            end else if (req && bus.cpu_MemWrite_i) begin
               word_mask[wsel] = 1'b1;
               meta_we         = 1'b1;
               meta_wr         = line_meta_t'{valid: 1'b1, dirty: 1'b1, tag: req_tag};
            end
         end
         WRITEBACK: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_write_o  = 1'b1;
            bus.mem_addr_o   = line_addr(meta.tag, idx);
            bus.mem_data_o   = line;
            if (bus.mem_ack_i) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_addr_o   = line_addr(req_tag, idx);
            if (bus.mem_ack_i) begin
               line_we = 1'b1;
               meta_we = 1'b1;
               meta_wr = line_meta_t'{valid: 1'b1, dirty: 1'b0, tag: req_tag};
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // CPU-facing stall and load data; a stalled or missing read returns zero.
   always_comb begin
      bus.cpu_stall_o = req && ((state_q != IDLE) || !hit);
      bus.cpu_data_o  = '0;
      if ((state_q == IDLE) && bus.cpu_MemRead_i && hit) begin
         bus.cpu_data_o = line[wsel*WORD_W +: WORD_W];
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl with a fixed-latency backing-memory model.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   localparam int L         = 3;
   localparam int STALL_MAX = 40;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [127:0] data;
   } mem_txn_t;

   typedef struct {
      int          stall;
      logic [31:0] rdata;
   } cpu_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dcache_if bus ();

   dcache_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   mem_txn_t     mem_q [$];
   cpu_exp_t     cpu_q [$];
   logic [127:0] mem_arr [bit [31:0]];
   int           n_checks   = 0;
   int           n_pass     = 0;
   int           stray_req  = 0;
   int           stray_done = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [127:0] mem_line(input bit [31:0] a);
      logic [127:0] l;
      if (mem_arr.exists(a)) return mem_arr[a];
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'hC0DE_0000 ^ (a + 32'(w * 4));
      return l;
   endfunction

   // Backing memory: acks L cycles after the first enable cycle, checks each transaction.
   initial begin
      int       cnt;
      mem_txn_t t;
      cnt            = 0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.mem_ack_i  = 1'b0;
         bus.mem_data_i = '0;
         if (stray_req != stray_done) begin
            stray_done++;
            bus.mem_ack_i = 1'b1;
            cnt           = 0;
         end else if (bus.mem_enable_o) begin
            if (cnt == L) begin
               cnt           = 0;
               bus.mem_ack_i = 1'b1;
               if (mem_q.size() == 0) begin
                  check_eq("mem_unexpected_txn", 128'(bus.mem_addr_o), 128'hFFFF_FFFF_FFFF);
               end else begin
                  t = mem_q.pop_front();
                  check_eq("mem_write", 128'(bus.mem_write_o), 128'(t.wr));
                  check_eq("mem_addr", 128'(bus.mem_addr_o), 128'(t.addr));
                  if (t.wr) check_eq("mem_wdata", bus.mem_data_o, t.data);
               end
               if (bus.mem_write_o) mem_arr[bus.mem_addr_o] = bus.mem_data_o;
               else                 bus.mem_data_i = mem_line(bus.mem_addr_o);
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // One CPU access held until the stall drops; stall count and load data are scored.
   task automatic access(input string name, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_stall, input logic [31:0] exp_rdata);
      cpu_exp_t e;
      int       stalls;
      stalls = 0;
      @(posedge clk);
      #1;
      bus.cpu_addr_i     = addr;
      bus.cpu_data_i     = wdata;
      bus.cpu_MemRead_i  = rd;
      bus.cpu_MemWrite_i = wr;
      cpu_q.push_back('{exp_stall, rd ? exp_rdata : 32'h0});
      forever begin
         @(negedge clk);
         if (!bus.cpu_stall_o) break;
         stalls++;
         if (stalls > STALL_MAX) break;
      end
      e = cpu_q.pop_front();
      check_eq({name, "_stall_cycles"}, 128'(stalls), 128'(e.stall));
      if (stalls <= STALL_MAX) begin
         check_eq({name, "_cpu_data"}, 128'(bus.cpu_data_o), 128'(e.rdata));
         check_eq({name, "_mem_enable"}, 128'(bus.mem_enable_o), 128'(0));
      end
      @(posedge clk);
      #1;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      check_eq({name, "_mem_txns_done"}, 128'(mem_q.size()), 128'(0));
   endtask

   initial begin
      logic [127:0] l;
      bus.cpu_addr_i     = '0;
      bus.cpu_data_i     = '0;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      mem_arr[32'h40]    = {32'h33, 32'h22, 32'h11, 32'h00};

      // Reset state.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_stall", 128'(bus.cpu_stall_o), 128'(0));
      check_eq("rst_mem_enable", 128'(bus.mem_enable_o), 128'(0));
      check_eq("rst_mem_write", 128'(bus.mem_write_o), 128'(0));
      check_eq("rst_mem_addr", 128'(bus.mem_addr_o), 128'(0));
      check_eq("rst_mem_data", bus.mem_data_o, 128'(0));
      check_eq("rst_cpu_data", 128'(bus.cpu_data_o), 128'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // Cold read miss, read hit, write hit then read-back.
      mem_q.push_back('{1'b0, 32'h40, 128'(0)});
      access("cold_miss", 1'b1, 1'b0, 32'h40, 32'h0, 5, 32'h00);
      access("read_hit", 1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h11);
      access("write_hit", 1'b0, 1'b1, 32'h48, 32'hDEADBEEF, 0, 32'h0);
      access("read_after_write", 1'b1, 1'b0, 32'h48, 32'h0, 0, 32'hDEADBEEF);
      access("read_word3", 1'b1, 1'b0, 32'h4C, 32'h0, 0, 32'h33);

      // Conflict miss on a dirty line: write-back then refill.
      mem_q.push_back('{1'b1, 32'h40, {32'h33, 32'hDEADBEEF, 32'h11, 32'h00}});
      mem_q.push_back('{1'b0, 32'h140, 128'(0)});
      l = mem_line(32'h140);
      access("dirty_miss", 1'b1, 1'b0, 32'h148, 32'h0, 9, l[95:64]);

      // Write miss allocate on a clean index, then eviction writes it back.
      mem_q.push_back('{1'b0, 32'h200, 128'(0)});
      l = mem_line(32'h200);
      access("write_miss", 1'b0, 1'b1, 32'h200, 32'h5, 5, 32'h0);
      access("write_miss_readback", 1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h5);
      access("write_miss_neighbour", 1'b1, 1'b0, 32'h204, 32'h0, 0, l[63:32]);
      mem_q.push_back('{1'b1, 32'h200, {l[127:32], 32'h5}});
      mem_q.push_back('{1'b0, 32'h300, 128'(0)});
      l = mem_line(32'h300);
      access("evict_alloc_line", 1'b1, 1'b0, 32'h300, 32'h0, 9, l[31:0]);

      // Reset two cycles into ALLOCATE; a late ack must be ignored.
      @(posedge clk);
      #1;
      bus.cpu_addr_i    = 32'h50;
      bus.cpu_MemRead_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst               = 1'b1;
      bus.cpu_MemRead_i = 1'b0;
      mem_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      stray_req++;
      @(negedge clk);
      check_eq("midrst_mem_enable", 128'(bus.mem_enable_o), 128'(0));
      check_eq("midrst_mem_addr", 128'(bus.mem_addr_o), 128'(0));
      check_eq("midrst_stall", 128'(bus.cpu_stall_o), 128'(0));
      @(negedge clk);
      check_eq("late_ack_ignored", 128'(bus.mem_enable_o), 128'(0));
      mem_q.push_back('{1'b0, 32'h40, 128'(0)});
      l = mem_line(32'h40);
      access("reread_after_rst", 1'b1, 1'b0, 32'h44, 32'h0, 5, l[63:32]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
